// File: rtl/data_packer_if.sv
// Beat, configuration and packed-row signals between the vector ALU, the packer and the trace buffer.
// The master side drives beats and configuration. The slave side (the packer) returns rows and status.
interface data_packer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int LW = $clog2(N + 1);

  logic                          tracing;
  logic                          valid_in;
  logic [1:0]                    eof_in;
  logic [CW-1:0]                 chainId_in;
  logic [7:0]                    configId;
  logic [7:0]                    configData;
  logic [N-1:0][DATA_WIDTH-1:0]  vector_in;
  logic [N-1:0][DATA_WIDTH-1:0]  vector_out;
  logic                          valid_out;
  logic [LW-1:0]                 lanes_out;
  logic                          eof_out;
  logic                          error_out;

  modport master (
    output tracing, valid_in, eof_in, chainId_in, configId, configData, vector_in,
    input  vector_out, valid_out, lanes_out, eof_out, error_out
  );

  modport slave (
    input  tracing, valid_in, eof_in, chainId_in, configId, configData, vector_in,
    output vector_out, valid_out, lanes_out, eof_out, error_out
  );
endinterface

// File: rtl/data_packer.sv
// Packs the first S lanes of each committed vector into dense N-lane rows for the trace buffer.
// Lane rotation wraps by truncation, so N must be a power of two.
module data_packer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input logic         clk,
  input logic         rst_n,
  data_packer_if.slave ifc
);
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int FW = $clog2(N);
  localparam int LW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH_PEND} state_t;
  typedef logic [N-1:0][DATA_WIDTH-1:0] row_t;

  state_t                    state_reg, state_next;
  row_t                      pack_reg, pack_next;
  logic [FW-1:0]             fill_reg, fill_next;
  logic [MAX_CHAINS-1:0]     commit_reg, commit_next;
  logic [MAX_CHAINS-1:0][7:0] size_reg, size_next;
  logic [7:0]                byte_cnt_reg, byte_cnt_next;
  row_t                      vector_out_reg, vector_out_next;
  logic                      valid_out_reg, valid_out_next;
  logic [LW-1:0]             lanes_out_reg, lanes_out_next;
  logic                      eof_out_reg, eof_out_next;
  logic                      error_reg, error_next;

  logic [7:0]                size_sel;
  logic [LW-1:0]             eff_size;
  logic [LW-1:0]             sum;
  logic [LW-1:0]             leftover;
  logic                      beat, accept, flush, emit_full;
  logic [7:0]                size_idx;
  logic [N-1:0][FW-1:0]      lane_idx;
  row_t                      rot, row, newbuf, flush_row, pend_row;
  logic                      unused_group_eof;

  // End-of-group has no effect on packing; only end-of-frame flushes.
  assign unused_group_eof = ifc.eof_in[0];

  assign size_sel = size_reg[ifc.chainId_in];
  assign eff_size = (size_sel == 8'd0 || size_sel > 8'(N)) ? LW'(N) : size_sel[LW-1:0];

  assign beat      = ifc.tracing && ifc.valid_in && (state_reg != FLUSH_PEND);
  assign accept    = beat && commit_reg[ifc.chainId_in];
  assign flush     = beat && ifc.eof_in[1];
  assign sum       = LW'(fill_reg) + (accept ? eff_size : LW'(0));
  assign emit_full = accept && (sum >= LW'(N));
  assign leftover  = emit_full ? sum - LW'(N) : sum;
  assign size_idx  = byte_cnt_reg - 8'(MAX_CHAINS);

  // Per lane: which beat element lands here, the completed row, and the retained buffer.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane_idx[gi]  = FW'(gi) - fill_reg;
      assign rot[gi]       = ifc.vector_in[lane_idx[gi]];
      assign newbuf[gi]    = (LW'(lane_idx[gi]) < eff_size) ? rot[gi] : pack_reg[gi];
      assign row[gi]       = (FW'(gi) < fill_reg) ? pack_reg[gi] : rot[gi];
      assign flush_row[gi] = (LW'(gi) < leftover) ? newbuf[gi] : '0;
      assign pend_row[gi]  = (FW'(gi) < fill_reg) ? pack_reg[gi] : '0;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    pack_next       = pack_reg;
    fill_next       = fill_reg;
    commit_next     = commit_reg;
    size_next       = size_reg;
    byte_cnt_next   = byte_cnt_reg;
    error_next      = error_reg;
    vector_out_next = '0;
    valid_out_next  = 1'b0;
    lanes_out_next  = '0;
    eof_out_next    = 1'b0;

    if (state_reg == FLUSH_PEND) begin
      // Second half of a double-row flush; any beat now is lost.
      valid_out_next  = 1'b1;
      lanes_out_next  = LW'(fill_reg);
      vector_out_next = pend_row;
      eof_out_next    = 1'b1;
      fill_next       = '0;
      state_next      = IDLE;
      if (ifc.tracing && ifc.valid_in) begin
        error_next = 1'b1;
      end
    end else if (!ifc.tracing) begin
      if (ifc.configId == 8'(PERSONAL_CONFIG_ID)) begin
        if (byte_cnt_reg < 8'(MAX_CHAINS)) begin
          commit_next[byte_cnt_reg[CW-1:0]] = ifc.configData[0];
        end else if (byte_cnt_reg < 8'(2 * MAX_CHAINS)) begin
          size_next[size_idx[CW-1:0]] = ifc.configData;
        end
        // Saturating keeps trailing bytes ignored however long the stream runs.
        if (byte_cnt_reg < 8'(2 * MAX_CHAINS)) begin
          byte_cnt_next = byte_cnt_reg + 8'd1;
        end
      end else begin
        byte_cnt_next = '0;
      end
    end else begin
      if (accept) begin
        pack_next = newbuf;
      end
      fill_next  = leftover[FW-1:0];
      state_next = (leftover == '0) ? IDLE : PACK;
      if (emit_full) begin
        valid_out_next  = 1'b1;
        lanes_out_next  = LW'(N);
        vector_out_next = row;
      end
      if (flush) begin
        if (emit_full && leftover != '0) begin
          state_next = FLUSH_PEND;
        end else begin
          fill_next    = '0;
          state_next   = IDLE;
          eof_out_next = 1'b1;
          if (!emit_full) begin
            valid_out_next  = 1'b1;
            lanes_out_next  = leftover;
            vector_out_next = flush_row;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pack_reg       <= '0;
      fill_reg       <= '0;
      commit_reg     <= '1;
      size_reg       <= '0;
      byte_cnt_reg   <= '0;
      vector_out_reg <= '0;
      valid_out_reg  <= 1'b0;
      lanes_out_reg  <= '0;
      eof_out_reg    <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pack_reg       <= pack_next;
      fill_reg       <= fill_next;
      commit_reg     <= commit_next;
      size_reg       <= size_next;
      byte_cnt_reg   <= byte_cnt_next;
      vector_out_reg <= vector_out_next;
      valid_out_reg  <= valid_out_next;
      lanes_out_reg  <= lanes_out_next;
      eof_out_reg    <= eof_out_next;
      error_reg      <= error_next;
    end
  end

  assign ifc.vector_out = vector_out_reg;
  assign ifc.valid_out  = valid_out_reg;
  assign ifc.lanes_out  = lanes_out_reg;
  assign ifc.eof_out    = eof_out_reg;
  assign ifc.error_out  = error_reg;
endmodule

// File: tb/tb_data_packer.sv
// Bench for data_packer: an element-queue model predicts every output cycle; literal checks pin key rows.
module tb_data_packer;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int MC = 4;
  localparam int VW = N * DW;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    int   cyc;
    vec_t vec;
    int   lanes;
    bit   eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t             exp_q[$];
  logic [DW-1:0]    pend[$];
  bit               m_commit[MC];
  int               m_size[MC];
  int               m_bc;
  int               err_cyc;
  int               fp_cyc;

  data_packer_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)) ifc ();

  data_packer #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifc   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] base);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = base + DW'(i);
    return v;
  endfunction

  function automatic int eff(input int s);
    return (s == 0 || s > N) ? N : s;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend.delete();
    for (int c = 0; c < MC; c++) begin
      m_commit[c] = 1'b1;
      m_size[c]   = 0;
    end
    m_bc    = 0;
    err_cyc = -1;
    fp_cyc  = -1;
  endtask

  // Every negedge: either the model has a row due this cycle or valid_out must be low.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("row_missed", VW'(0), VW'(1));
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("valid_out", VW'(ifc.valid_out), VW'(1));
      chk("lanes_out", VW'(ifc.lanes_out), VW'(e.lanes));
      chk("eof_out", VW'(ifc.eof_out), VW'(e.eof));
      chk("vector_out", VW'(ifc.vector_out), VW'(e.vec));
    end else begin
      chk("valid_idle", VW'(ifc.valid_out), VW'(0));
    end
    chk("error_out", VW'(ifc.error_out), VW'(err_cyc >= 0 && cyc >= err_cyc));
  end

  task automatic idle();
    @(posedge clk); #1;
    ifc.tracing  = 1'b1;
    ifc.valid_in = 1'b0;
    ifc.eof_in   = 2'b00;
    $display("cyc=%0d idle", cyc);
  endtask

  task automatic cfg(input logic [7:0] id, input logic [7:0] b);
    @(posedge clk); #1;
    ifc.tracing    = 1'b0;
    ifc.valid_in   = 1'b1;
    ifc.configId   = id;
    ifc.configData = b;
    if (id == 8'd0) begin
      if (m_bc < MC) m_commit[m_bc] = b[0];
      else if (m_bc < 2 * MC) m_size[m_bc - MC] = int'(b);
      m_bc++;
    end else begin
      m_bc = 0;
    end
    $display("cyc=%0d cfg id=%0d byte=%0h", cyc, id, b);
  endtask

  task automatic cfg_all(input int c0, input int c1, input int c2, input int c3,
                         input int s0, input int s1, input int s2, input int s3);
    int bytes[8];
    bytes = '{c0, c1, c2, c3, s0, s1, s2, s3};
    for (int i = 0; i < 8; i++) cfg(8'd0, 8'(bytes[i]));
    cfg(8'd1, 8'hFF);
  endtask

  task automatic beat(input int ch, input logic [1:0] eof, input vec_t v);
    int   k;
    bit   emitted;
    exp_t full_e, part_e;
    @(posedge clk); #1;
    ifc.tracing    = 1'b1;
    ifc.valid_in   = 1'b1;
    ifc.eof_in     = eof;
    ifc.chainId_in = 2'(ch);
    ifc.vector_in  = v;
    ifc.configId   = 8'd1;
    k = cyc;
    $display("cyc=%0d beat chain=%0d eof=%0b lane0=%0h", cyc, ch, eof, v[0]);
    if (k == fp_cyc) begin
      if (err_cyc < 0) err_cyc = k + 1;
    end else begin
      emitted = 1'b0;
      if (m_commit[ch]) for (int j = 0; j < eff(m_size[ch]); j++) pend.push_back(v[j]);
      if (pend.size() >= N) begin
        full_e = '{cyc: k + 1, vec: '0, lanes: N, eof: 1'b0};
        for (int i = 0; i < N; i++) full_e.vec[i] = pend.pop_front();
        emitted = 1'b1;
      end
      if (eof[1]) begin
        if (pend.size() == 0) begin
          if (emitted) full_e.eof = 1'b1;
          else exp_q.push_back('{cyc: k + 1, vec: '0, lanes: 0, eof: 1'b1});
        end else begin
          part_e = '{cyc: emitted ? k + 2 : k + 1, vec: '0, lanes: pend.size(), eof: 1'b1};
          for (int i = 0; i < part_e.lanes; i++) part_e.vec[i] = pend[i];
          if (emitted) fp_cyc = k + 1;
          pend.delete();
        end
      end
      if (emitted) exp_q.push_back(full_e);
      if (eof[1] && part_e.lanes > 0) exp_q.push_back(part_e);
    end
  endtask

  initial begin
    vec_t v;
    ifc.tracing    = 1'b1;
    ifc.valid_in   = 1'b0;
    ifc.eof_in     = 2'b00;
    ifc.chainId_in = '0;
    ifc.configId   = 8'd1;
    ifc.configData = 8'd0;
    ifc.vector_in  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("reset_vector", VW'(ifc.vector_out), VW'(0));
    chk("reset_lanes", VW'(ifc.lanes_out), VW'(0));
    chk("reset_eof", VW'(ifc.eof_out), VW'(0));

    // chain0 size1, chain1 size3, chain2 size4, chain3 size N
    cfg_all(1, 1, 1, 1, 1, 3, 4, 0);

    // Test 1: eight size-1 beats build one row 1..8
    for (int i = 1; i <= 8; i++) begin
      v = mk(32'hEE00_0000 + 32'(i * 16));
      v[0] = 32'(i);
      beat(0, 2'b00, v);
    end
    idle();
    chk("t1_lanes", VW'(ifc.lanes_out), VW'(8));
    chk("t1_lane0", VW'(ifc.vector_out[0]), VW'(1));
    chk("t1_lane7", VW'(ifc.vector_out[7]), VW'(8));

    // Test 2: size3 beats A,B,C then frame end D
    beat(1, 2'b00, mk(32'hA0));
    beat(1, 2'b00, mk(32'hB0));
    beat(1, 2'b00, mk(32'hC0));
    idle();
    chk("t2_lane5", VW'(ifc.vector_out[5]), VW'(32'hB2));
    chk("t2_lane6", VW'(ifc.vector_out[6]), VW'(32'hC0));
    beat(1, 2'b10, mk(32'hD0));
    idle();
    chk("t2_flush_lanes", VW'(ifc.lanes_out), VW'(4));
    chk("t2_flush_eof", VW'(ifc.eof_out), VW'(1));
    chk("t2_flush_lane0", VW'(ifc.vector_out[0]), VW'(32'hC2));
    chk("t2_flush_lane4", VW'(ifc.vector_out[4]), VW'(0));

    // Test 3: fill 6 + size4 frame end -> double row; beat during pending flush is dropped
    beat(1, 2'b00, mk(32'hE0));
    beat(1, 2'b00, mk(32'hF0));
    beat(2, 2'b10, mk(32'h60));
    beat(0, 2'b00, mk(32'h70));
    chk("t3_full_eof", VW'(ifc.eof_out), VW'(0));
    chk("t3_full_lane7", VW'(ifc.vector_out[7]), VW'(32'h61));
    idle();
    chk("t3_part_lanes", VW'(ifc.lanes_out), VW'(2));
    chk("t3_part_lane1", VW'(ifc.vector_out[1]), VW'(32'h63));
    chk("t3_error", VW'(ifc.error_out), VW'(1));

    // Test 4: partial stream, foreign id resets the counter, then full stream
    cfg(8'd0, 8'd0);
    cfg(8'd0, 8'd1);
    cfg(8'd0, 8'd1);
    cfg(8'd7, 8'h55);
    cfg_all(0, 1, 1, 1, 2, 0, 0, 0);
    beat(0, 2'b00, mk(32'h300));
    idle();
    chk("t4_drop", VW'(ifc.valid_out), VW'(0));
    beat(1, 2'b00, mk(32'h400));
    idle();
    chk("t4_lanes", VW'(ifc.lanes_out), VW'(8));
    chk("t4_lane3", VW'(ifc.vector_out[3]), VW'(32'h403));
    beat(0, 2'b10, mk(32'h500));
    idle();
    chk("t4_marker_lanes", VW'(ifc.lanes_out), VW'(0));
    chk("t4_marker_eof", VW'(ifc.eof_out), VW'(1));

    // Test 5: async reset with fill=5 while a row is on the outputs
    cfg_all(1, 1, 1, 1, 1, 3, 5, 0);
    beat(2, 2'b00, mk(32'h600));
    beat(3, 2'b00, mk(32'h700));
    idle();
    chk("t5_pre_valid", VW'(ifc.valid_out), VW'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_vector", VW'(ifc.vector_out), VW'(0));
    chk("t5_rst_valid", VW'(ifc.valid_out), VW'(0));
    chk("t5_rst_error", VW'(ifc.error_out), VW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    cfg_all(1, 1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      v = mk(32'hCC00_0000);
      v[0] = 32'h100 + 32'(i);
      beat(0, 2'b00, v);
    end
    idle();
    chk("t5_lanes", VW'(ifc.lanes_out), VW'(8));
    chk("t5_lane0", VW'(ifc.vector_out[0]), VW'(32'h100));
    chk("t5_lane7", VW'(ifc.vector_out[7]), VW'(32'h107));
    beat(0, 2'b10, mk(32'h800));
    idle();
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
